// File: rtl/clz_divider.sv
// Multi-cycle signed/unsigned 32-bit radix-2 restoring divider. The dividend's
// leading-zero count from an external CLZ sets the iteration count.
module clz_divider #(
    parameter logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sign,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] abs_dividend,
    output logic [31:0] abs_divisor,
    input  logic [31:0] dividend_lz,
    input  logic [31:0] divisor_lz,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic [1:0]  fsm_state
);
    // Handshake: start is sampled only while idle (including the done cycle);
    // busy covers SCAN/RUN/SIGN; done pulses for one cycle when results land.
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, RUN = 2'd2, SIGN = 2'd3} state_t;

    state_t      state, state_next;
    logic [31:0] raw_dividend;
    logic [31:0] shift_reg;
    logic [32:0] rem;
    logic [31:0] q_reg;
    logic [5:0]  count;
    logic        q_neg, r_neg, fix_en;

    logic [5:0]  lz_a, lz_b;
    logic [31:0] mag_a, mag_b;
    logic        div_zero, early;
    logic [32:0] rem_shift, rem_sub;
    logic        q_bit;
    logic        lz_unused;

    assign lz_a      = dividend_lz[5:0];
    assign lz_b      = divisor_lz[5:0];
    assign lz_unused = ^{dividend_lz[31:6], divisor_lz[31:6]};
    assign mag_a     = (sign && dividend[31]) ? -dividend : dividend;
    assign mag_b     = (sign && divisor[31]) ? -divisor : divisor;
    assign div_zero  = (abs_divisor == 32'd0);
    // Fewer significant bits in the dividend means quotient 0 outright.
    assign early     = (lz_a > lz_b);

    assign rem_shift = {rem[31:0], shift_reg[31]};
    assign q_bit     = (rem_shift >= {1'b0, abs_divisor});
    assign rem_sub   = rem_shift - {1'b0, abs_divisor};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = SCAN;
            SCAN: state_next = (div_zero || early) ? SIGN : RUN;
            RUN:  if (count == 6'd1) state_next = SIGN;
            SIGN: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        fsm_state = state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            abs_dividend <= '0;
            abs_divisor  <= '0;
            raw_dividend <= '0;
            shift_reg    <= '0;
            rem          <= '0;
            q_reg        <= '0;
            count        <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            fix_en       <= 1'b0;
            done         <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
        end else begin
            done <= (state == SIGN);
            case (state)
                IDLE: if (start) begin
                    raw_dividend <= dividend;
                    abs_dividend <= mag_a;
                    abs_divisor  <= mag_b;
                    q_neg        <= sign & (dividend[31] ^ divisor[31]);
                    r_neg        <= sign & dividend[31];
                    fix_en       <= 1'b1;
                end
                SCAN: begin
                    if (div_zero) begin
                        // Raw dividend is returned untouched, so no sign fix.
                        q_reg  <= DIV_ZERO_Q;
                        rem    <= {1'b0, raw_dividend};
                        fix_en <= 1'b0;
                    end else if (early) begin
                        q_reg <= '0;
                        rem   <= {1'b0, abs_dividend};
                    end else begin
                        shift_reg <= abs_dividend << lz_a;
                        rem       <= '0;
                        q_reg     <= '0;
                        count     <= 6'(7'd32 - {1'b0, lz_a});
                    end
                end
                RUN: begin
                    shift_reg <= shift_reg << 1;
                    rem       <= q_bit ? rem_sub : rem_shift;
                    q_reg     <= {q_reg[30:0], q_bit};
                    count     <= count - 6'd1;
                end
                SIGN: begin
                    quotient  <= (q_neg && fix_en) ? -q_reg : q_reg;
                    remainder <= (r_neg && fix_en) ? -rem[31:0] : rem[31:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_clz_divider.sv
// Directed bench for clz_divider with a behavioural CLZ on the abs_* outputs
// and a queue scoreboard of expected quotient/remainder/latency.
module tb_clz_divider;
    localparam logic [31:0] DZQ = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sign = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] abs_dividend, abs_divisor, dividend_lz, divisor_lz;
    logic [31:0] quotient, remainder;
    logic        busy, done;
    logic [1:0]  fsm_state;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q_q[$];
    logic [31:0] exp_r_q[$];
    int          exp_lat_q[$];
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;

    always #5 clk = ~clk;

    function automatic logic [31:0] clz32(input logic [31:0] x);
        logic [31:0] n;
        n = 32;
        for (int i = 0; i < 32; i++) if (x[i]) n = 32'(31 - i);
        return n;
    endfunction

    function automatic logic [31:0] mag(input logic s, input logic [31:0] x);
        return (s && x[31]) ? (~x + 32'd1) : x;
    endfunction

    assign dividend_lz = clz32(abs_dividend);
    assign divisor_lz  = clz32(abs_divisor);

    clz_divider dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sign(sign),
        .dividend(dividend), .divisor(divisor),
        .abs_dividend(abs_dividend), .abs_divisor(abs_divisor),
        .dividend_lz(dividend_lz), .divisor_lz(divisor_lz),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .fsm_state(fsm_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a clock edge; the next edge accepts the request.
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, eq, er;
        logic signed [31:0] sa, sb;
        int lat;
        ma = mag(s, a);
        mb = mag(s, b);
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            eq = DZQ; er = a;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                eq = 32'h8000_0000; er = 32'd0;
            end else begin
                eq = 32'(sa / sb); er = 32'(sa % sb);
            end
        end else begin
            eq = a / b; er = a % b;
        end
        if (b == 32'd0 || clz32(ma) > clz32(mb)) lat = 3;
        else lat = 35 - int'(clz32(ma));
        exp_q_q.push_back(eq);
        exp_r_q.push_back(er);
        exp_lat_q.push_back(lat);
        sign = s; dividend = a; divisor = b; start = 1'b1;
    endtask

    // Returns positioned in the done cycle (just after its opening edge).
    task automatic finish_op(input string tag, input int poke);
        int cyc;
        bit busy_ok, hold_ok;
        logic [31:0] eq, er;
        int el;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; busy_ok = 1'b1; hold_ok = 1'b1;
        while (done !== 1'b1 && cyc <= 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (quotient !== last_q || remainder !== last_r) hold_ok = 1'b0;
            if (cyc == poke) begin
                start = 1'b1; sign = 1'b0;
                dividend = $urandom; divisor = $urandom_range(1, 9);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        eq = exp_q_q.pop_front();
        er = exp_r_q.pop_front();
        el = exp_lat_q.pop_front();
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(el));
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " busy_during"}, 32'(busy_ok), 32'd1);
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check({tag, " result_hold"}, 32'(hold_ok), 32'd1);
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        logic s;
        logic [31:0] a, b;
        int done_seen;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset abs_dividend", abs_dividend, 32'd0);
        check("reset abs_divisor", abs_divisor, 32'd0);
        check("reset state", 32'(fsm_state), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        start_op(1'b0, 32'd100, 32'd7);
        finish_op("divu_100_7", 0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("held_quotient", quotient, 32'd14);

        start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_m7_2", 0);
        check("div_m7_2 abs_dividend", abs_dividend, 32'd7);
        check("div_m7_2 abs_divisor", abs_divisor, 32'd2);
        @(posedge clk); #1;

        start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_min_m1", 0);
        @(posedge clk); #1;

        start_op(1'b0, 32'd5, 32'd0);
        finish_op("divu_5_0", 0);
        // Remaining ops below start in the previous op's done cycle.
        start_op(1'b1, 32'hFFFF_FFFB, 32'd0);
        finish_op("div_m5_0", 0);
        start_op(1'b0, 32'd3, 32'd100);
        finish_op("divu_3_100", 0);
        start_op(1'b0, 32'd0, 32'd9);
        finish_op("divu_0_9", 0);
        start_op(1'b1, 32'hFFFF_FFFD, 32'd100);
        finish_op("div_m3_100", 0);

        @(posedge clk); #1;
        start_op(1'b0, 32'd100, 32'd7);
        finish_op("start_in_run", 4);

        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            s = 1'($urandom_range(0, 1));
            a = $urandom >> $urandom_range(0, 31);
            b = $urandom >> $urandom_range(0, 31);
            if (b == 32'd0) b = 32'd1;
            if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            start_op(s, a, b);
            finish_op("random", 0);
        end

        // Reset asserted across the edge ending RUN cycle 4 of 100/7.
        @(posedge clk); #1;
        sign = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midreset state", 32'(fsm_state), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset quotient", quotient, 32'd0);
        check("midreset remainder", remainder, 32'd0);
        done_seen = 0;
        repeat (12) begin
            if (done === 1'b1) done_seen++;
            @(posedge clk); #1;
        end
        check("midreset no_done", 32'(done_seen), 32'd0);
        last_q = '0;
        last_r = '0;

        start_op(1'b0, 32'd1000, 32'd10);
        finish_op("after_reset", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clz_divider.md
Name: clz_divider

Overview:
- Multi-cycle signed/unsigned 32-bit divider in the CPU execute stage, directly downstream of two CLZ instances.
- Drives operand magnitudes out to the CLZ instances and consumes their leading-zero counts back. The dividend count sets the iteration count, so DIV/DIVU cost only as many cycles as the dividend has significant bits.
- Provides the start/busy/done handshake that the pipeline stall logic uses.

Parameters:
- DIV_ZERO_Q, 32'hFFFF_FFFF: quotient returned when the divisor is zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- sign  in  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  in  32  operand A.
- divisor  in  32  operand B.
- abs_dividend  out  32  latched magnitude of A; drives the CLZ instance for A.
- abs_divisor  out  32  latched magnitude of B; drives the CLZ instance for B.
- dividend_lz  in  32  CLZ count of abs_dividend (0..32); only bits [5:0] are used.
- divisor_lz  in  32  CLZ count of abs_divisor (0..32); only bits [5:0] are used.
- busy  out  1  high while in SCAN, RUN or SIGN.
- done  out  1  one-cycle pulse; quotient and remainder are valid from this cycle.
- quotient  out  32  result, held until the next accepted start.
- remainder  out  32  result, held until the next accepted start.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. busy, done, quotient, remainder, abs_dividend, abs_divisor and all internal registers = 0. This applies mid-operation too; the operation in flight is discarded with no done pulse.
- Magnitude rule:
  - sign=1 and operand bit31=1: magnitude = two's-complement negation.
  - Otherwise magnitude = operand.
  - Negation of 0x8000_0000 yields 0x8000_0000, treated as unsigned.
- IDLE:
  - On start=1: latch sign, the raw dividend, both magnitudes (onto abs_* outputs), q_neg = sign&(A31^B31), r_neg = sign&A31. Go to SCAN.
  - start is ignored in every other state.
  - start in the same cycle as done is accepted.
- SCAN (1 cycle): the CLZ counts are valid (purely combinational from abs_*). Let N = 32 - dividend_lz[5:0].
  - abs_divisor==0: q=DIV_ZERO_Q, r=raw dividend, sign fix suppressed. Go to SIGN.
  - Else if dividend_lz > divisor_lz (dividend magnitude < divisor magnitude, including dividend 0): q=0, r=abs_dividend. Go to SIGN.
  - Else: shift register = abs_dividend << dividend_lz, partial remainder = 0, counter = N. Go to RUN.
- RUN (exactly N cycles, one radix-2 restoring step per cycle):
  - rem' = {rem[31:0], msb of shift reg}; shift reg <<= 1.
  - If rem' >= abs_divisor: rem' -= abs_divisor, q bit = 1; else q bit = 0.
  - q shifts left taking the new bit at the LSB.
  - Partial remainder is 33 bits wide so the compare never overflows.
  - Counter decrements; after the step with counter==1, go to SIGN.
- SIGN (1 cycle): quotient = q_neg ? -q : q; remainder = r_neg ? -r : r. Result registers are written. Go to IDLE with done=1 for that next cycle.
  - 0x8000_0000 / 0xFFFF_FFFF (signed) therefore gives q=0x8000_0000, r=0 with no trap.
- Latency, with the start-accepted cycle = cycle 0:
  - Normal path: SCAN cycle 1, RUN cycles 2..N+1, SIGN cycle N+2, done high in cycle N+3.
  - Zero-divisor and early-out paths: done high in cycle 3.
  - Maximum 35 cycles (N=32).
- busy is high in cycles 1..N+2, low in the done cycle.
- quotient/remainder change only on the SIGN write.

Test Plan:
- DIVU 100/7: dividend_lz=25, N=7 -> done in cycle 10, q=14, r=2; busy high cycles 1..9.
- DIV 0xFFFF_FFF9 (-7) / 2: abs_dividend=7, abs_divisor=2 -> q=0xFFFF_FFFD (-3), r=0xFFFF_FFFF (-1).
- DIV 0x8000_0000 / 0xFFFF_FFFF: N=32 -> done in cycle 35, q=0x8000_0000, r=0.
- DIVU 5/0 -> done in cycle 3, q=0xFFFF_FFFF, r=5. DIV 0xFFFF_FFFB/0 -> r=0xFFFF_FFFB, unmodified.
- DIVU 3/100 and 0/9 (early-out) -> done in cycle 3, q=0, r=3 and r=0 respectively.
- Handshake/reset:
  - start pulsed during RUN -> ignored, result unchanged.
  - start in the done cycle -> new op accepted.
  - rst_n=0 for one edge in RUN cycle 4 -> next cycle IDLE, busy=0, q=r=0, no done pulse.
